// File: rtl/vga_scanout.sv
// vga_scanout: prefetches each display line from SDRAM (Avalon-MM burst reads) into a
// ping-pong line buffer and drives RGB444. Optional test pattern: VGA_SCANOUT_TEST_PATTERN_EN.
module vga_scanout #(
  parameter logic [31:0] FB_BASE0   = 32'h0800_0000,
  parameter logic [31:0] FB_BASE1   = 32'h0809_6000,
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_TOTAL    = 525,
  parameter int          STRIDE     = 1280,
  parameter int          BURST_LEN  = 8,
  parameter int          SCALE_LOG2 = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic        visible,
  input  logic        pixel_ce,
  input  logic        fb_sel,
  input  logic        underflow_clr,
  input  logic        test_mode,
  output logic        avalon_master_read,
  output logic [31:0] avalon_master_address,
  output logic [7:0]  avalon_master_burstcount,
  input  logic [31:0] avalon_master_readdata,
  input  logic        avalon_master_waitrequest,
  input  logic        avalon_master_readdatavalid,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        underflow,
  output logic        fb_active
);

  localparam int WORDS = H_ACTIVE >> (SCALE_LOG2 + 1);
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WW    = AW + 1;
  localparam int BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BEATS} state_t;

  state_t         r_state, w_state_nxt;
  logic [31:0]    r_address;
  logic [WW-1:0]  r_w;
  logic [BW-1:0]  r_beat;
  logic           r_bank;
  logic           r_fb_active;
  logic           r_underflow;

  // Only the 12 colour bits of each pixel half are stored.
  logic [23:0]    r_bank0 [WORDS];
  logic [23:0]    r_bank1 [WORDS];
  logic [23:0]    r_rd_data;
  logic           r_pix_vld, r_half, r_vis, r_tp;
  logic [2:0]     r_tp_idx;
  logic [3:0]     r_red, r_green, r_blue;

  logic           w_tp_block, w_trigger, w_frame_start, w_fetch_req, w_accept, w_drop;
  logic           w_beat, w_last_beat, w_more;
  logic [9:0]     w_line, w_src, w_rd_x, w_hx;
  logic [AW-1:0]  w_rd_idx;
  logic [31:0]    w_base, w_start_addr;
  logic [23:0]    w_wr_data;

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  logic [7:0]     w_unused_bits;
  assign w_tp_block    = test_mode;
  assign w_unused_bits = {avalon_master_readdata[31:28], avalon_master_readdata[15:12]};
`else
  logic [8:0]     w_unused_bits;
  assign w_tp_block    = 1'b0;
  assign w_unused_bits = {avalon_master_readdata[31:28], avalon_master_readdata[15:12], test_mode};
`endif

  // Fetch request decode: frame start refetches line 0, otherwise prefetch the next line.
  assign w_trigger     = pixel_ce && (draw_x == 10'(H_ACTIVE)) && !w_tp_block;
  assign w_frame_start = (draw_y == 10'(V_TOTAL - 1));
  assign w_fetch_req   = w_trigger && (w_frame_start || (draw_y < 10'(V_ACTIVE - 1)));
  assign w_accept      = w_fetch_req && (r_state == S_IDLE);
  assign w_drop        = w_fetch_req && (r_state != S_IDLE);
  assign w_line        = w_frame_start ? 10'd0 : draw_y + 10'd1;
  assign w_src         = w_line >> SCALE_LOG2;
  assign w_base        = (w_frame_start ? fb_sel : r_fb_active) ? FB_BASE1 : FB_BASE0;
  assign w_start_addr  = w_base + 32'(w_src) * 32'(STRIDE);

  // Beats landing while reset is asserted must not touch the line buffer.
  assign w_beat      = (r_state == S_BEATS) && avalon_master_readdatavalid && !reset;
  assign w_last_beat = w_beat && (r_beat == BW'(BURST_LEN - 1));
  assign w_more      = (int'(r_w) + 1) < WORDS;
  assign w_wr_data   = {avalon_master_readdata[27:16], avalon_master_readdata[11:0]};

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    w_state_nxt        = r_state;
    avalon_master_read = 1'b0;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_REQ;
      S_REQ: begin
        avalon_master_read = 1'b1;
        if (!avalon_master_waitrequest) w_state_nxt = S_BEATS;
      end
      S_BEATS: if (w_last_beat) w_state_nxt = w_more ? S_REQ : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_address   <= '0;
      r_w         <= '0;
      r_beat      <= '0;
      r_bank      <= 1'b0;
      r_fb_active <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_frame_start) r_fb_active <= fb_sel;
        r_address <= w_start_addr;
        r_w       <= '0;
        r_beat    <= '0;
        r_bank    <= w_line[0];
      end
      if (w_beat) begin
        r_w    <= r_w + 1'b1;
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
        if (w_last_beat) r_address <= r_address + 32'(BURST_LEN * 4);
      end
      // A dropped fetch in the same cycle as a clear keeps the flag set.
      if (w_drop)             r_underflow <= 1'b1;
      else if (underflow_clr) r_underflow <= 1'b0;
    end
  end

  // Display side: line y lives in bank y[0]; beyond the active width the index is clamped.
  assign w_rd_x   = draw_x >> (SCALE_LOG2 + 1);
  assign w_hx     = draw_x >> SCALE_LOG2;
  assign w_rd_idx = (w_rd_x < 10'(WORDS)) ? w_rd_x[AW-1:0] : '0;

  // NOTE: line-buffer RAM and its read register are deliberately not reset; the
  // pipeline control and colour registers below carry the reset state instead.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      if (r_bank) r_bank1[r_w[AW-1:0]] <= w_wr_data;
      else        r_bank0[r_w[AW-1:0]] <= w_wr_data;
    end
    if (pixel_ce) r_rd_data <= draw_y[0] ? r_bank1[w_rd_idx] : r_bank0[w_rd_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix_vld <= 1'b0;
      r_half    <= 1'b0;
      r_vis     <= 1'b0;
      r_tp      <= 1'b0;
      r_tp_idx  <= '0;
      r_red     <= '0;
      r_green   <= '0;
      r_blue    <= '0;
    end else begin
      r_pix_vld <= pixel_ce;
      if (pixel_ce) begin
        r_half   <= w_hx[0];
        r_vis    <= visible;
        r_tp     <= w_tp_block;
        r_tp_idx <= draw_x[9:7];
      end
      if (r_pix_vld) begin
        if (!r_vis) begin
          r_red <= '0; r_green <= '0; r_blue <= '0;
        end else if (r_tp) begin
          r_red <= {4{r_tp_idx[2]}}; r_green <= {4{r_tp_idx[1]}}; r_blue <= {4{r_tp_idx[0]}};
        end else if (r_half) begin
          r_red <= r_rd_data[23:20]; r_green <= r_rd_data[19:16]; r_blue <= r_rd_data[15:12];
        end else begin
          r_red <= r_rd_data[11:8];  r_green <= r_rd_data[7:4];   r_blue <= r_rd_data[3:0];
        end
      end
    end
  end

  assign avalon_master_address    = r_address;
  assign avalon_master_burstcount = 8'(BURST_LEN);
  assign red       = r_red;
  assign green     = r_green;
  assign blue      = r_blue;
  assign underflow = r_underflow;
  assign fb_active = r_fb_active;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks of vga_scanout (default build plus a SCALE_LOG2=1 instance)
// against a negedge-driven Avalon burst slave whose data is a known function of address.
module tb_vga_scanout;

  localparam int          BL   = 8;
  localparam logic [31:0] KEY0 = 32'h0ABC0123;
  localparam logic [31:0] KEY1 = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  draw_x = '0, draw_y = '0;
  logic        visible = 1'b0, pixel_ce = 1'b0, fb_sel = 1'b0;
  logic        underflow_clr = 1'b0, test_mode = 1'b0;

  logic        rd1, rd2;
  logic [31:0] addr1, addr2;
  logic [7:0]  bc1, bc2;
  logic [31:0] rdata1 = '0, rdata2 = '0;
  logic        wreq1 = 1'b0, wreq2 = 1'b0, rdv1 = 1'b0, rdv2 = 1'b0;
  logic [3:0]  r1, g1, b1, r2, g2, b2;
  logic        uf1, uf2, fa1, fa2;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] data_key = KEY0;
  int          cfg_wait = 0;
  bit          hold1 = 1'b0;
  int          wcnt1 = 0, pend1 = 0, nb1 = 0, stab_err = 0, pend2 = 0, nb2 = 0;
  logic [31:0] req_addr1 = '0, paddr1 = '0, first1 = '0, last_word1 = '0;
  logic [31:0] paddr2 = '0, first2 = '0;

  always #5 clk = ~clk;

  vga_scanout u_dut (
    .clk(clk), .reset(reset), .draw_x(draw_x), .draw_y(draw_y), .visible(visible),
    .pixel_ce(pixel_ce), .fb_sel(fb_sel), .underflow_clr(underflow_clr), .test_mode(test_mode),
    .avalon_master_read(rd1), .avalon_master_address(addr1), .avalon_master_burstcount(bc1),
    .avalon_master_readdata(rdata1), .avalon_master_waitrequest(wreq1),
    .avalon_master_readdatavalid(rdv1),
    .red(r1), .green(g1), .blue(b1), .underflow(uf1), .fb_active(fa1)
  );

  vga_scanout #(.SCALE_LOG2(1)) u_dut_s2 (
    .clk(clk), .reset(reset), .draw_x(draw_x), .draw_y(draw_y), .visible(visible),
    .pixel_ce(pixel_ce), .fb_sel(fb_sel), .underflow_clr(underflow_clr), .test_mode(test_mode),
    .avalon_master_read(rd2), .avalon_master_address(addr2), .avalon_master_burstcount(bc2),
    .avalon_master_readdata(rdata2), .avalon_master_waitrequest(wreq2),
    .avalon_master_readdatavalid(rdv2),
    .red(r2), .green(g2), .blue(b2), .underflow(uf2), .fb_active(fa2)
  );

  // Slave for the main instance: programmable waitrequest, withheld beats, stability tracking.
  always @(negedge clk) begin
    rdv1 = 1'b0;
    if (pend1 > 0 && !hold1) begin
      rdv1       = 1'b1;
      rdata1     = data_key ^ {paddr1[15:0], paddr1[15:0]};
      last_word1 = paddr1;
      paddr1     = paddr1 + 32'd4;
      pend1      = pend1 - 1;
    end
    if (reset) begin
      wcnt1 = 0;
      wreq1 = 1'b0;
    end else if (rd1) begin
      if (wcnt1 == 0) req_addr1 = addr1;
      else if (addr1 != req_addr1) stab_err = stab_err + 1;
      if (wcnt1 < cfg_wait) begin
        wreq1 = 1'b1;
        wcnt1 = wcnt1 + 1;
      end else begin
        wreq1 = 1'b0;
        wcnt1 = 0;
        if (nb1 == 0) first1 = addr1;
        nb1    = nb1 + 1;
        pend1  = BL;
        paddr1 = addr1;
      end
    end else begin
      if (wcnt1 != 0) stab_err = stab_err + 1;
      wreq1 = 1'b0;
    end
  end

  // Slave for the pixel-doubling instance: zero wait, immediate beats.
  always @(negedge clk) begin
    rdv2 = 1'b0;
    if (pend2 > 0) begin
      rdv2   = 1'b1;
      rdata2 = data_key ^ {paddr2[15:0], paddr2[15:0]};
      paddr2 = paddr2 + 32'd4;
      pend2  = pend2 - 1;
    end
    if (!reset && rd2) begin
      if (nb2 == 0) first2 = addr2;
      nb2    = nb2 + 1;
      pend2  = BL;
      paddr2 = addr2;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] get_rgb(input int sel);
    return (sel != 0) ? {r2, g2, b2} : {r1, g1, b1};
  endfunction

  task automatic trig(input int y);
    @(negedge clk);
    draw_x = 10'd640; draw_y = 10'(y); pixel_ce = 1'b1;
    @(negedge clk);
    pixel_ce = 1'b0; draw_x = '0;
  endtask

  task automatic pixel(input int sel, input int x, input int y, input bit vis,
                       input logic [11:0] prev, input logic [11:0] exp, input string tag);
    @(negedge clk);
    draw_x = 10'(x); draw_y = 10'(y); visible = vis; pixel_ce = 1'b1;
    @(negedge clk);
    pixel_ce = 1'b0; visible = 1'b0;
    check({tag, "_1clk"}, 32'(get_rgb(sel)), 32'(prev));
    @(negedge clk);
    check({tag, "_2clk"}, 32'(get_rgb(sel)), 32'(exp));
  endtask

  task automatic wait_done(input int sel, input int n, input string tag);
    bit done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(posedge clk);
      done = (sel != 0) ? (nb2 >= n && pend2 == 0) : (nb1 >= n && pend1 == 0);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_pend(input string tag);
    bit seen = 1'b0;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      @(posedge clk);
      seen = (pend1 > 0);
    end
    check({tag, "_accepted"}, 32'(seen), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_read", 32'(rd1), 32'd0);
    check("rst_addr", addr1, 32'd0);
    check("rst_rgb", 32'(get_rgb(0)), 32'd0);
    check("rst_uf", 32'(uf1), 32'd0);
    check("rst_fa", 32'(fa1), 32'd0);
    check("burstcount", 32'(bc1), 32'd8);
    reset = 1'b0;

    // Frame start, buffer 0
    nb1 = 0;
    trig(524);
    wait_done(0, 40, "fetch_fb0");
    check("fb0_fa", 32'(fa1), 32'd0);
    check("fb0_first", first1, 32'h0800_0000);
    check("fb0_last", last_word1, 32'h0800_04FC);
    check("fb0_bursts", 32'(nb1), 32'd40);
    check("fb0_idle", 32'(rd1), 32'd0);

    // Pixel halves, latency and blanking
    pixel(0, 0, 0, 1'b1, 12'h000, 12'h123, "pix_x0");
    pixel(0, 1, 0, 1'b1, 12'h123, 12'hABC, "pix_x1");
    pixel(0, 2, 0, 1'b0, 12'hABC, 12'h000, "pix_invis");

    // Last visible line requests nothing
    trig(479);
    @(negedge clk);
    check("no_fetch_479", 32'(rd1), 32'd0);

    // Page flip to buffer 1
    fb_sel = 1'b1;
    nb1 = 0;
    trig(524);
    check("flip_fa", 32'(fa1), 32'd1);
    wait_done(0, 40, "fetch_fb1");
    check("fb1_first", first1, 32'h0809_6000);
    check("fb1_last", last_word1, 32'h0809_64FC);
    check("fb1_bursts", 32'(nb1), 32'd40);

    // Slave stalls 10 clk per request
    cfg_wait = 10; nb1 = 0; stab_err = 0;
    trig(0);
    repeat (5) @(negedge clk);
    check("wait_read_held", 32'(rd1), 32'd1);
    check("wait_addr_held", addr1, 32'h0809_6500);
    wait_done(0, 40, "fetch_wait");
    check("wait_first", first1, 32'h0809_6500);
    check("wait_stable", 32'(stab_err), 32'd0);
    cfg_wait = 0;

    // Underflow: beats withheld across further triggers
    hold1 = 1'b1; nb1 = 0;
    trig(1);
    wait_pend("uf_fetch");
    check("uf_before", 32'(uf1), 32'd0);
    trig(2);
    check("uf_set", 32'(uf1), 32'd1);
    repeat (3) @(negedge clk);
    check("uf_sticky", 32'(uf1), 32'd1);
    @(negedge clk);
    draw_x = 10'd640; draw_y = 10'd3; pixel_ce = 1'b1; underflow_clr = 1'b1;
    @(negedge clk);
    pixel_ce = 1'b0; draw_x = '0; underflow_clr = 1'b0;
    check("uf_clr_drop", 32'(uf1), 32'd1);
    @(negedge clk);
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    check("uf_clr", 32'(uf1), 32'd0);
    hold1 = 1'b0;
    wait_done(0, 40, "fetch_uf");
    check("uf_no_extra", 32'(nb1), 32'd40);
    check("uf_idle", 32'(rd1), 32'd0);

    // Bank 0 now holds line 2 of buffer 1 (offset 0x6A00)
    pixel(0, 1, 0, 1'b1, 12'h000, 12'h0BC, "pix_line2");

    // Reset during a stalled request
    cfg_wait = 20;
    trig(10);
    repeat (2) @(negedge clk);
    trig(11);
    check("uf_in_req", 32'(uf1), 32'd1);
    check("req_before_rst", 32'(rd1), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_read_drop", 32'(rd1), 32'd0);
    repeat (2) @(negedge clk);
    check("rst2_uf", 32'(uf1), 32'd0);
    check("rst2_addr", addr1, 32'd0);
    check("rst2_fa", 32'(fa1), 32'd0);
    check("rst2_rgb", 32'(get_rgb(0)), 32'd0);
    reset = 1'b0;
    cfg_wait = 0;

    // Reload bank 0, then reset mid-burst while new data is in flight
    fb_sel = 1'b0; nb1 = 0;
    trig(524);
    wait_done(0, 40, "reload");
    data_key = KEY1; hold1 = 1'b1; nb1 = 0;
    trig(524);
    wait_pend("late_fetch");
    @(negedge clk);
    reset = 1'b1; hold1 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_done(0, 1, "late_drain");
    check("late_idle", 32'(rd1), 32'd0);
    pixel(0, 0, 0, 1'b1, 12'h000, 12'h123, "late_beats_ignored");

    // Pixel doubling: line 5 comes from source line 2
    data_key = KEY0; nb1 = 0; nb2 = 0;
    trig(4);
    wait_done(1, 20, "s2_fetch");
    wait_done(0, 40, "line5_fetch");
    check("s2_addr", first2, 32'h0800_0A00);
    check("s2_bursts", 32'(nb2), 32'd20);
    check("line5_addr", first1, 32'h0800_1900);
    pixel(1, 0, 5, 1'b1, 12'h000, 12'hB23, "s2_x0");
    pixel(1, 1, 5, 1'b1, 12'hB23, 12'hB23, "s2_x1");
    pixel(1, 2, 5, 1'b1, 12'hB23, 12'h0BC, "s2_x2");
    pixel(1, 3, 5, 1'b1, 12'h0BC, 12'h0BC, "s2_x3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
